// File: rtl/decade_ctrl_pkg.sv
// Shared state encoding and default parameters for the decade counter controller.
// Optional build macro: DECADE_CTRL_SYNC_EN (two-flop button synchronizers).
package decade_ctrl_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_RUN   = 2'd1;
  localparam logic [STATE_W-1:0] ST_PAUSE = 2'd2;
  localparam logic [STATE_W-1:0] ST_DONE  = 2'd3;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = ST_IDLE,
    RUN   = ST_RUN,
    PAUSE = ST_PAUSE,
    DONE  = ST_DONE
  } state_t;

  localparam int DEF_TC    = 9;
  localparam int DEF_LAPS  = 3;
  localparam int DEF_LAP_W = 4;

endpackage

// File: rtl/decade_ctrl_rise.sv
// Button rising-edge detector producing a registered one-cycle command.
// With DECADE_CTRL_SYNC_EN defined, the button first crosses a two-flop synchronizer.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic rise
);

  logic btn_s;
  logic prev_reg;
  logic rise_reg;

`ifdef DECADE_CTRL_SYNC_EN
  logic [1:0] sync_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], in};
    end
  end

  assign btn_s = sync_reg[1];
`else
  assign btn_s = in;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_reg <= 1'b0;
      rise_reg <= 1'b0;
    end else begin
      prev_reg <= btn_s;
      rise_reg <= btn_s & ~prev_reg;
    end
  end

  assign rise = rise_reg;

endmodule

// File: rtl/decade_ctrl.sv
// Run/pause/stop sequencer for the decade counter: button commands, lap counting, DONE after LAPS wraps.
// Optional build macro: DECADE_CTRL_SYNC_EN (adds two-flop synchronizers on the buttons).
module decade_ctrl
  import decade_ctrl_pkg::*;
#(
  parameter int LAPS  = DEF_LAPS,
  parameter int LAP_W = DEF_LAP_W,
  parameter int TC    = DEF_TC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic [3:0]       count,
  output logic             cnt_en,
  output logic             cnt_clr,
  output logic             busy,
  output logic             done,
  output logic             wrap,
  output logic [LAP_W-1:0] lap
);

  localparam logic [3:0]       TC_V   = 4'(TC);
  localparam logic [LAP_W-1:0] LAPS_V = LAP_W'(LAPS);

  logic [2:0] btn;
  logic [2:0] btn_rise;
  logic       start_rise, stop_rise, clear_rise;

  assign btn = {clear, stop, start};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_btn
      rise_detect u_rise (
        .clk  (clk),
        .reset(reset),
        .in   (btn[gi]),
        .rise (btn_rise[gi])
      );
    end
  endgenerate

  assign start_rise = btn_rise[0];
  assign stop_rise  = btn_rise[1];
  assign clear_rise = btn_rise[2];

  state_t           state_reg, state_next;
  logic [LAP_W-1:0] lap_reg, lap_next, lap_inc;
  logic             cnt_en_reg, cnt_clr_reg, busy_reg, done_reg, wrap_reg;
  logic             clr_next, wrap_next, wrap_evt;

  // The datapath only advances when enabled and not being cleared.
  assign wrap_evt = cnt_en_reg & ~cnt_clr_reg & (count == TC_V);
  assign lap_inc  = lap_reg + LAP_W'(1);

  always_comb begin
    state_next = state_reg;
    lap_next   = lap_reg;
    clr_next   = 1'b0;
    wrap_next  = 1'b0;
    if (clear_rise) begin
      state_next = IDLE;
      lap_next   = '0;
      clr_next   = 1'b1;
    end else if (wrap_evt) begin
      lap_next  = lap_inc;
      wrap_next = 1'b1;
      if (lap_inc == LAPS_V) begin
        state_next = DONE;
      end else if (stop_rise) begin
        state_next = PAUSE;
      end
    end else if (stop_rise && state_reg == RUN) begin
      state_next = PAUSE;
    end else if (start_rise) begin
      case (state_reg)
        IDLE, DONE: begin
          state_next = RUN;
          lap_next   = '0;
          clr_next   = 1'b1;
        end
        PAUSE:   state_next = RUN;
        default: state_next = state_reg;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      lap_reg     <= '0;
      cnt_en_reg  <= 1'b0;
      cnt_clr_reg <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      wrap_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      lap_reg     <= lap_next;
      cnt_clr_reg <= clr_next;
      wrap_reg    <= wrap_next;
      cnt_en_reg  <= (state_next == RUN);
      busy_reg    <= (state_next == RUN) || (state_next == PAUSE);
      done_reg    <= (state_next == DONE);
    end
  end

  assign cnt_en  = cnt_en_reg;
  assign cnt_clr = cnt_clr_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;
  assign wrap    = wrap_reg;
  assign lap     = lap_reg;

endmodule

// File: tb/tb_decade_ctrl.sv
// Directed scoreboard bench: decade_ctrl driving a 0..9 counter whose count loops back.
module tb_decade_ctrl;

`ifdef DECADE_CTRL_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0, stop = 1'b0, clear = 1'b0;
  logic [3:0] count;
  logic       cnt_en, cnt_clr, busy, done, wrap;
  logic [3:0] lap;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [12:0] val;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  decade_ctrl #(.LAPS(3), .LAP_W(4), .TC(9)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .stop   (stop),
    .clear  (clear),
    .count  (count),
    .cnt_en (cnt_en),
    .cnt_clr(cnt_clr),
    .busy   (busy),
    .done   (done),
    .wrap   (wrap),
    .lap    (lap)
  );

  // Decade counter datapath: clear has priority over enable.
  always @(posedge clk or posedge reset) begin
    if (reset)        count <= 4'd0;
    else if (cnt_clr) count <= 4'd0;
    else if (cnt_en)  count <= (count == 4'd9) ? 4'd0 : count + 4'd1;
  end

  function automatic logic [12:0] mk(input logic en, input logic clr, input logic bsy,
                                     input logic dn, input logic wr, input int lp, input int cnt);
    logic [3:0] lp4, cnt4;
    lp4  = 4'(lp);
    cnt4 = 4'(cnt);
    return {en, clr, bsy, dn, wr, lp4, cnt4};
  endfunction

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic push(input string tag, input logic [12:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    logic [12:0] obs;
    obs = {cnt_en, cnt_clr, busy, done, wrap, lap, count};
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL sb_empty observed=%h required=queued_entry", obs);
    end else begin
      e = sb.pop_front();
      $display("txn %s observed=%h expected=%h", e.tag, obs, e.val);
      assert (obs === e.val) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic expect_after(input string tag, input int n, input logic [12:0] v);
    push(tag, v);
    step(n);
    check();
  endtask

  // One-cycle button pulse; returns on the cycle the resulting state is visible.
  task automatic press(input logic s, input logic p, input logic c, input string tag,
                       input logic [12:0] v);
    push(tag, v);
    start = s; stop = p; clear = c;
    step(1);
    start = 1'b0; stop = 1'b0; clear = 1'b0;
    step(LAT);
    check();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step(2);
    expect_after("reset_state", 0, mk(0,0,0,0,0,0,0));
    reset = 1'b0;
    step(2);

    // Full run to DONE
    press(1,0,0, "start_clr", mk(1,1,1,0,0,0,0));
    expect_after("first_zero", 1, mk(1,0,1,0,0,0,0));
    for (int l = 1; l <= 3; l++) begin
      expect_after("count_nine", 9, mk(1,0,1,0,0,l-1,9));
      if (l == 3) expect_after("final_wrap", 1, mk(0,0,0,1,1,3,0));
      else        expect_after("wrap", 1, mk(1,0,1,0,1,l,0));
    end
    expect_after("done_hold", 1, mk(0,0,0,1,0,3,0));

    // Restart from DONE, pause at 5, resume
    press(1,0,0, "restart_done", mk(1,1,1,0,0,0,0));
    expect_after("restart_zero", 1, mk(1,0,1,0,0,0,0));
    step(5 - (LAT + 1));
    press(0,1,0, "pause_at5", mk(0,0,1,0,0,0,5));
    expect_after("pause_hold", 3, mk(0,0,1,0,0,0,5));
    press(1,0,0, "resume_noclr", mk(1,0,1,0,0,0,5));
    expect_after("resume_six", 1, mk(1,0,1,0,0,0,6));
    expect_after("lap1_wrap", 4, mk(1,0,1,0,1,1,0));

    // Clear in RUN at count 7 with lap 1
    step(7 - (LAT + 1));
    press(0,0,1, "clear_run", mk(0,1,0,0,0,0,7));
    expect_after("clear_idle", 1, mk(0,0,0,0,0,0,0));

    // Simultaneous start/stop/clear: clear wins
    press(1,1,1, "all_three", mk(0,1,0,0,0,0,0));
    expect_after("all_idle", 1, mk(0,0,0,0,0,0,0));

    // Stop coinciding with the final wrap
    press(1,0,0, "start2", mk(1,1,1,0,0,0,0));
    expect_after("start2_zero", 1, mk(1,0,1,0,0,0,0));
    expect_after("lap1", 10, mk(1,0,1,0,1,1,0));
    expect_after("lap2", 10, mk(1,0,1,0,1,2,0));
    expect_after("pre_stop", 9 - LAT, mk(1,0,1,0,0,2,9 - LAT));
    press(0,1,0, "stop_final", mk(0,0,0,1,1,3,0));

    // Start held for 50 cycles from DONE: one command only
    push("held_start", mk(1,1,1,0,0,0,0));
    start = 1'b1;
    step(1 + LAT);
    check();
    expect_after("held_done", 48, mk(0,0,0,1,0,3,0));
    start = 1'b0;
    expect_after("held_release", 3, mk(0,0,0,1,0,3,0));

    // Reset mid-RUN at count 4
    press(1,0,0, "start3", mk(1,1,1,0,0,0,0));
    expect_after("run_four", 5, mk(1,0,1,0,0,0,4));
    push("async_reset", mk(0,0,0,0,0,0,0));
    reset = 1'b1;
    #1;
    check();
    step(1);
    reset = 1'b0;
    expect_after("post_reset", 5, mk(0,0,0,0,0,0,0));
    press(1,0,0, "start_after_rst", mk(1,1,1,0,0,0,0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
